// File: rtl/otter_pkg.sv
// Shared OTTER types: instruction fields, forwarding-select encoding and the
// hazard scoreboard slot, plus the "slot produces register" predicate.
package otter_pkg;

    typedef enum logic [6:0] {
        OP_LUI    = 7'b0110111,
        OP_AUIPC  = 7'b0010111,
        OP_JAL    = 7'b1101111,
        OP_JALR   = 7'b1100111,
        OP_BRANCH = 7'b1100011,
        OP_LOAD   = 7'b0000011,
        OP_STORE  = 7'b0100011,
        OP_IMM    = 7'b0010011,
        OP_REG    = 7'b0110011,
        OP_SYS    = 7'b1110011
    } opcode_t;

    typedef struct packed {
        logic [6:0] funct7;
        logic [4:0] rs2;
        logic [4:0] rs1;
        logic [2:0] funct3;
        logic [4:0] rd;
        opcode_t    opcode;
    } instr_t;

    typedef enum logic [1:0] {
        FWD_RF    = 2'd0,
        FWD_EXMEM = 2'd1,
        FWD_MEMWB = 2'd2
    } fwd_sel_t;

    typedef struct packed {
        logic       v;
        logic [4:0] rd;
        logic       wr;
        logic       ld;
    } sb_slot_t;

    localparam sb_slot_t SLOT_BUBBLE = '0;

    // x0 is hardwired to zero, so a write to it never creates a dependency.
    function automatic logic slotProduces(input sb_slot_t s, input logic [4:0] r);
        return s.v & s.wr & (s.rd == r) & (r != 5'd0);
    endfunction

endpackage

// File: rtl/otter_hazard_ctrl_if.sv
// Signal bundle between the OTTER pipeline (master) and the hazard
// controller (slave).
interface otter_hazard_ctrl_if #(parameter int CNT_W = 16);
    import otter_pkg::*;

    logic             de_valid;
    logic [4:0]       de_rs1_addr;
    logic [4:0]       de_rs2_addr;
    logic             de_rs1_used;
    logic             de_rs2_used;
    logic [4:0]       de_rd_addr;
    logic             de_reg_write;
    logic             de_is_load;
    logic             ex_redirect;
    logic             mem_busy;

    logic             pc_stall;
    logic             if_de_stall;
    logic             if_de_flush;
    logic             de_ex_flush;
    logic             pipe_hold;
    fwd_sel_t         fwd_a_sel;
    fwd_sel_t         fwd_b_sel;
    logic             de_byp_a;
    logic             de_byp_b;
    logic [CNT_W-1:0] stall_cnt;
    logic [CNT_W-1:0] flush_cnt;

    modport master (
        output de_valid, de_rs1_addr, de_rs2_addr, de_rs1_used, de_rs2_used,
               de_rd_addr, de_reg_write, de_is_load, ex_redirect, mem_busy,
        input  pc_stall, if_de_stall, if_de_flush, de_ex_flush, pipe_hold,
               fwd_a_sel, fwd_b_sel, de_byp_a, de_byp_b, stall_cnt, flush_cnt
    );

    modport slave (
        input  de_valid, de_rs1_addr, de_rs2_addr, de_rs1_used, de_rs2_used,
               de_rd_addr, de_reg_write, de_is_load, ex_redirect, mem_busy,
        output pc_stall, if_de_stall, if_de_flush, de_ex_flush, pipe_hold,
               fwd_a_sel, fwd_b_sel, de_byp_a, de_byp_b, stall_cnt, flush_cnt
    );

endinterface

// File: rtl/otter_hazard_ctrl_sat_counter.sv
// Event counter that sticks at all-ones instead of wrapping.
module sat_counter #(
    parameter int W = 16
) (
    input  logic         CLK,
    input  logic         RST_N,
    input  logic         inc,
    output logic [W-1:0] cnt
);

    logic [W-1:0] cnt_q;
    logic [W-1:0] cnt_d;

    always_comb begin
        cnt_d = cnt_q;
        if (inc && (cnt_q != '1)) begin
            cnt_d = cnt_q + W'(1);
        end
    end

    always_ff @(posedge CLK) begin
        if (!RST_N) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end

    assign cnt = cnt_q;

endmodule

// File: rtl/otter_hazard_ctrl.sv
// OTTER 5-stage hazard controller: shadow scoreboard of in-flight writers,
// forwarding selects, load-use/RAW stalls, redirect flushes and memory freeze.
module otter_hazard_ctrl
    import otter_pkg::*;
#(
    parameter bit FWD_EN = 1'b1,
    parameter int CNT_W  = 16
) (
    input  logic                CLK,
    input  logic                RST_N,
    otter_hazard_ctrl_if.slave  hz
);

    sb_slot_t exSlot_q, memSlot_q, wbSlot_q;
    sb_slot_t exSlot_d, memSlot_d, wbSlot_d;
    fwd_sel_t fwdA_q, fwdB_q;
    fwd_sel_t fwdA_d, fwdB_d;

    logic aHitEx, aHitMem, aHitWb;
    logic bHitEx, bHitMem, bHitWb;
    logic loadUse, rawHit, stallReq;
    logic freeze, applyRedirect, applyStall;

    function automatic fwd_sel_t fwdSel(input logic hitEx, input logic hitMem);
        if (!FWD_EN) return FWD_RF;
        if (hitEx)   return FWD_EXMEM;
        if (hitMem)  return FWD_MEMWB;
        return FWD_RF;
    endfunction

    assign aHitEx  = hz.de_valid & hz.de_rs1_used & slotProduces(exSlot_q,  hz.de_rs1_addr);
    assign aHitMem = hz.de_valid & hz.de_rs1_used & slotProduces(memSlot_q, hz.de_rs1_addr);
    assign aHitWb  = hz.de_valid & hz.de_rs1_used & slotProduces(wbSlot_q,  hz.de_rs1_addr);
    assign bHitEx  = hz.de_valid & hz.de_rs2_used & slotProduces(exSlot_q,  hz.de_rs2_addr);
    assign bHitMem = hz.de_valid & hz.de_rs2_used & slotProduces(memSlot_q, hz.de_rs2_addr);
    assign bHitWb  = hz.de_valid & hz.de_rs2_used & slotProduces(wbSlot_q,  hz.de_rs2_addr);

    assign loadUse  = (aHitEx | bHitEx) & exSlot_q.ld;
    assign rawHit   = aHitEx | bHitEx | aHitMem | bHitMem;
    assign stallReq = FWD_EN ? loadUse : rawHit;

    // Freeze outranks everything; a redirect outranks a stall because the
    // stalled DE instruction is on the wrong path anyway.
    assign freeze        = hz.mem_busy;
    assign applyRedirect = hz.ex_redirect & ~freeze;
    assign applyStall    = stallReq & ~hz.ex_redirect & ~freeze;

    assign hz.pc_stall    = freeze | applyStall;
    assign hz.if_de_stall = freeze | applyStall;
    assign hz.if_de_flush = applyRedirect;
    assign hz.de_ex_flush = applyRedirect | applyStall;
    assign hz.pipe_hold   = freeze;
    assign hz.de_byp_a    = aHitWb;
    assign hz.de_byp_b    = bHitWb;
    assign hz.fwd_a_sel   = fwdA_q;
    assign hz.fwd_b_sel   = fwdB_q;

    always_comb begin
        exSlot_d  = exSlot_q;
        memSlot_d = memSlot_q;
        wbSlot_d  = wbSlot_q;
        fwdA_d    = fwdA_q;
        fwdB_d    = fwdB_q;
        if (!freeze) begin
            wbSlot_d  = memSlot_q;
            memSlot_d = exSlot_q;
            if (applyRedirect || applyStall) begin
                exSlot_d = SLOT_BUBBLE;
                fwdA_d   = FWD_RF;
                fwdB_d   = FWD_RF;
            end else begin
                exSlot_d = '{v: hz.de_valid, rd: hz.de_rd_addr,
                             wr: hz.de_reg_write, ld: hz.de_is_load};
                fwdA_d   = fwdSel(aHitEx, aHitMem);
                fwdB_d   = fwdSel(bHitEx, bHitMem);
            end
        end
    end

    always_ff @(posedge CLK) begin
        if (!RST_N) begin
            exSlot_q  <= SLOT_BUBBLE;
            memSlot_q <= SLOT_BUBBLE;
            wbSlot_q  <= SLOT_BUBBLE;
            fwdA_q    <= FWD_RF;
            fwdB_q    <= FWD_RF;
        end else begin
            exSlot_q  <= exSlot_d;
            memSlot_q <= memSlot_d;
            wbSlot_q  <= wbSlot_d;
            fwdA_q    <= fwdA_d;
            fwdB_q    <= fwdB_d;
        end
    end

    sat_counter #(.W(CNT_W)) uStallCnt (
        .CLK   (CLK),
        .RST_N (RST_N),
        .inc   (freeze | applyStall),
        .cnt   (hz.stall_cnt)
    );

    sat_counter #(.W(CNT_W)) uFlushCnt (
        .CLK   (CLK),
        .RST_N (RST_N),
        .inc   (applyRedirect),
        .cnt   (hz.flush_cnt)
    );

endmodule

// File: tb/tb_otter_hazard_ctrl.sv
// Bench for otter_hazard_ctrl: three instances (forwarding, no forwarding,
// 2-bit counters) share one stimulus stream; expected outputs flow through a queue.
module tb_otter_hazard_ctrl;
    import otter_pkg::*;

    typedef struct packed {
        logic        rst;
        logic        v;
        logic [4:0]  rs1;
        logic        u1;
        logic [4:0]  rs2;
        logic        u2;
        logic [4:0]  rd;
        logic        wr;
        logic        ld;
        logic        redir;
        logic        busy;
        logic [10:0] exp;
    } stimT;

    // Output vector: pc_stall, if_de_stall, if_de_flush, de_ex_flush,
    // pipe_hold, fwd_a[1:0], fwd_b[1:0], byp_a, byp_b
    localparam logic [10:0] E_NONE   = 11'b0_0_0_0_0_00_00_0_0;
    localparam logic [10:0] E_STALL  = 11'b1_1_0_1_0_00_00_0_0;
    localparam logic [10:0] E_FLUSH  = 11'b0_0_1_1_0_00_00_0_0;
    localparam logic [10:0] E_FREEZE = 11'b1_1_0_0_1_00_00_0_0;

    logic       CLK = 1'b0;
    logic       RST_N;
    logic       deValid, rs1Used, rs2Used, regWrite, isLoad, redirect, memBusy;
    logic [4:0] rs1Addr, rs2Addr, rdAddr;

    int          checks = 0;
    int          failures = 0;
    logic [10:0] expQ[$];

    always #5 CLK = ~CLK;

    otter_hazard_ctrl_if #(.CNT_W(16)) hz0 ();
    otter_hazard_ctrl_if #(.CNT_W(16)) hz1 ();
    otter_hazard_ctrl_if #(.CNT_W(2))  hz2 ();

    otter_hazard_ctrl #(.FWD_EN(1'b1), .CNT_W(16)) dutFwd   (.CLK(CLK), .RST_N(RST_N), .hz(hz0));
    otter_hazard_ctrl #(.FWD_EN(1'b0), .CNT_W(16)) dutNoFwd (.CLK(CLK), .RST_N(RST_N), .hz(hz1));
    otter_hazard_ctrl #(.FWD_EN(1'b1), .CNT_W(2))  dutSat   (.CLK(CLK), .RST_N(RST_N), .hz(hz2));

    assign hz0.de_valid     = deValid;  assign hz1.de_valid     = deValid;  assign hz2.de_valid     = deValid;
    assign hz0.de_rs1_addr  = rs1Addr;  assign hz1.de_rs1_addr  = rs1Addr;  assign hz2.de_rs1_addr  = rs1Addr;
    assign hz0.de_rs2_addr  = rs2Addr;  assign hz1.de_rs2_addr  = rs2Addr;  assign hz2.de_rs2_addr  = rs2Addr;
    assign hz0.de_rs1_used  = rs1Used;  assign hz1.de_rs1_used  = rs1Used;  assign hz2.de_rs1_used  = rs1Used;
    assign hz0.de_rs2_used  = rs2Used;  assign hz1.de_rs2_used  = rs2Used;  assign hz2.de_rs2_used  = rs2Used;
    assign hz0.de_rd_addr   = rdAddr;   assign hz1.de_rd_addr   = rdAddr;   assign hz2.de_rd_addr   = rdAddr;
    assign hz0.de_reg_write = regWrite; assign hz1.de_reg_write = regWrite; assign hz2.de_reg_write = regWrite;
    assign hz0.de_is_load   = isLoad;   assign hz1.de_is_load   = isLoad;   assign hz2.de_is_load   = isLoad;
    assign hz0.ex_redirect  = redirect; assign hz1.ex_redirect  = redirect; assign hz2.ex_redirect  = redirect;
    assign hz0.mem_busy     = memBusy;  assign hz1.mem_busy     = memBusy;  assign hz2.mem_busy     = memBusy;

    logic [10:0] obs0, obs1, obs2;
    assign obs0 = {hz0.pc_stall, hz0.if_de_stall, hz0.if_de_flush, hz0.de_ex_flush, hz0.pipe_hold,
                   hz0.fwd_a_sel, hz0.fwd_b_sel, hz0.de_byp_a, hz0.de_byp_b};
    assign obs1 = {hz1.pc_stall, hz1.if_de_stall, hz1.if_de_flush, hz1.de_ex_flush, hz1.pipe_hold,
                   hz1.fwd_a_sel, hz1.fwd_b_sel, hz1.de_byp_a, hz1.de_byp_b};
    assign obs2 = {hz2.pc_stall, hz2.if_de_stall, hz2.if_de_flush, hz2.de_ex_flush, hz2.pipe_hold,
                   hz2.fwd_a_sel, hz2.fwd_b_sel, hz2.de_byp_a, hz2.de_byp_b};

    function automatic stimT mk(input logic v, input logic [4:0] rs1, input logic u1,
                                input logic [4:0] rs2, input logic u2, input logic [4:0] rd,
                                input logic wr, input logic ld, input logic redir,
                                input logic busy, input logic [10:0] exp);
        stimT s;
        s = '{rst: 1'b0, v: v, rs1: rs1, u1: u1, rs2: rs2, u2: u2, rd: rd,
              wr: wr, ld: ld, redir: redir, busy: busy, exp: exp};
        return s;
    endfunction

    task automatic driveStim(input stimT s);
        RST_N    = ~s.rst;
        deValid  = s.v;
        rs1Addr  = s.rs1;
        rs1Used  = s.u1;
        rs2Addr  = s.rs2;
        rs2Used  = s.u2;
        rdAddr   = s.rd;
        regWrite = s.wr;
        isLoad   = s.ld;
        redirect = s.redir;
        memBusy  = s.busy;
        expQ.push_back(s.exp);
    endtask

    task automatic doReset();
        RST_N = 1'b0;
        deValid = 0; rs1Used = 0; rs2Used = 0; regWrite = 0; isLoad = 0;
        redirect = 0; memBusy = 0; rs1Addr = 0; rs2Addr = 0; rdAddr = 0;
        @(posedge CLK);
        @(posedge CLK);
        #1;
        RST_N = 1'b1;
    endtask

    task automatic test_reset();
        doReset();
        @(negedge CLK);
        checks++; if (obs0 !== E_NONE) begin failures++; $display("[TB] FAIL reset.outs0 got=%b want=%b", obs0, E_NONE); end
        checks++; if (obs1 !== E_NONE) begin failures++; $display("[TB] FAIL reset.outs1 got=%b want=%b", obs1, E_NONE); end
        checks++; if (obs2 !== E_NONE) begin failures++; $display("[TB] FAIL reset.outs2 got=%b want=%b", obs2, E_NONE); end
        checks++; if (hz0.stall_cnt !== 16'd0) begin failures++; $display("[TB] FAIL reset.stall_cnt got=%0d want=0", hz0.stall_cnt); end
        checks++; if (hz0.flush_cnt !== 16'd0) begin failures++; $display("[TB] FAIL reset.flush_cnt got=%0d want=0", hz0.flush_cnt); end
        checks++; if (hz2.stall_cnt !== 2'd0) begin failures++; $display("[TB] FAIL reset.sat_cnt got=%0d want=0", hz2.stall_cnt); end
        @(posedge CLK); #1;
    endtask

    task automatic test_forwarding();
        stimT        seq[$];
        logic [10:0] got, want;
        doReset();
        seq.push_back(mk(1, 1, 1, 2, 1,  5, 1, 0, 0, 0, E_NONE));
        seq.push_back(mk(1, 5, 1, 5, 1,  6, 1, 0, 0, 0, E_NONE));
        seq.push_back(mk(1, 1, 1, 2, 1, 11, 1, 0, 0, 0, 11'b0_0_0_0_0_01_01_0_0));
        seq.push_back(mk(1, 6, 1, 6, 1, 14, 1, 0, 0, 0, E_NONE));
        seq.push_back(mk(1,14, 1,11, 1, 15, 1, 0, 0, 0, 11'b0_0_0_0_0_10_10_0_0));
        seq.push_back(mk(1,11, 1, 0, 1, 16, 1, 0, 0, 0, 11'b0_0_0_0_0_01_10_1_0));
        seq.push_back(mk(0, 0, 0, 0, 0,  0, 0, 0, 0, 0, E_NONE));
        // x0 destinations, including a load, never stall or forward
        seq.push_back(mk(1, 1, 1, 2, 1,  0, 1, 1, 0, 0, E_NONE));
        seq.push_back(mk(1, 0, 1, 0, 1,  3, 1, 0, 0, 0, E_NONE));
        seq.push_back(mk(0, 0, 0, 0, 0,  0, 0, 0, 0, 0, E_NONE));
        foreach (seq[i]) begin
            driveStim(seq[i]);
            @(negedge CLK);
            got = obs0; want = expQ.pop_front();
            checks++;
            if (got !== want) begin failures++; $display("[TB] FAIL forwarding[%0d] got=%b want=%b", i, got, want); end
            @(posedge CLK); #1;
        end
    endtask

    task automatic test_load_use();
        stimT        seq[$];
        logic [10:0] got, want;
        doReset();
        seq.push_back(mk(1, 1, 1, 0, 0, 7, 1, 1, 0, 0, E_NONE));
        seq.push_back(mk(1, 7, 1, 0, 1, 8, 1, 0, 0, 0, E_STALL));
        seq.push_back(mk(1, 7, 1, 0, 1, 8, 1, 0, 0, 0, E_NONE));
        seq.push_back(mk(0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 11'b0_0_0_0_0_10_00_0_0));
        foreach (seq[i]) begin
            driveStim(seq[i]);
            @(negedge CLK);
            got = obs0; want = expQ.pop_front();
            checks++;
            if (got !== want) begin failures++; $display("[TB] FAIL load_use[%0d] got=%b want=%b", i, got, want); end
            @(posedge CLK); #1;
        end
        checks++; if (hz0.stall_cnt !== 16'd1) begin failures++; $display("[TB] FAIL load_use.stall_cnt got=%0d want=1", hz0.stall_cnt); end
        checks++; if (hz0.flush_cnt !== 16'd0) begin failures++; $display("[TB] FAIL load_use.flush_cnt got=%0d want=0", hz0.flush_cnt); end
    endtask

    task automatic test_raw_nofwd();
        stimT        seq[$];
        logic [10:0] got, want;
        doReset();
        seq.push_back(mk(1, 1, 1, 2, 1,  9, 1, 0, 0, 0, E_NONE));
        seq.push_back(mk(1, 9, 1, 3, 1, 10, 1, 0, 0, 0, E_STALL));
        seq.push_back(mk(1, 9, 1, 3, 1, 10, 1, 0, 0, 0, E_STALL));
        seq.push_back(mk(1, 9, 1, 3, 1, 10, 1, 0, 0, 0, 11'b0_0_0_0_0_00_00_1_0));
        seq.push_back(mk(0, 0, 0, 0, 0,  0, 0, 0, 0, 0, E_NONE));
        foreach (seq[i]) begin
            driveStim(seq[i]);
            @(negedge CLK);
            got = obs1; want = expQ.pop_front();
            checks++;
            if (got !== want) begin failures++; $display("[TB] FAIL raw_nofwd[%0d] got=%b want=%b", i, got, want); end
            @(posedge CLK); #1;
        end
        checks++; if (hz1.stall_cnt !== 16'd2) begin failures++; $display("[TB] FAIL raw_nofwd.stall_cnt got=%0d want=2", hz1.stall_cnt); end
    endtask

    task automatic test_redirect_vs_stall();
        stimT        seq[$];
        logic [10:0] got, want;
        doReset();
        seq.push_back(mk(1, 1, 1, 0, 0, 7, 1, 1, 0, 0, E_NONE));
        seq.push_back(mk(1, 7, 1, 0, 1, 8, 1, 0, 1, 0, E_FLUSH));
        seq.push_back(mk(0, 0, 0, 0, 0, 0, 0, 0, 0, 0, E_NONE));
        foreach (seq[i]) begin
            driveStim(seq[i]);
            @(negedge CLK);
            got = obs0; want = expQ.pop_front();
            checks++;
            if (got !== want) begin failures++; $display("[TB] FAIL redirect_vs_stall[%0d] got=%b want=%b", i, got, want); end
            @(posedge CLK); #1;
        end
        checks++; if (hz0.flush_cnt !== 16'd1) begin failures++; $display("[TB] FAIL redirect_vs_stall.flush_cnt got=%0d want=1", hz0.flush_cnt); end
        checks++; if (hz0.stall_cnt !== 16'd0) begin failures++; $display("[TB] FAIL redirect_vs_stall.stall_cnt got=%0d want=0", hz0.stall_cnt); end
    endtask

    task automatic test_freeze_redirect();
        stimT        seq[$];
        logic [10:0] got, want;
        doReset();
        seq.push_back(mk(1, 1, 1, 2, 1, 5, 1, 0, 0, 0, E_NONE));
        for (int k = 0; k < 3; k++) seq.push_back(mk(1, 5, 1, 5, 1, 6, 1, 0, 1, 1, E_FREEZE));
        seq.push_back(mk(1, 5, 1, 5, 1, 6, 1, 0, 1, 0, E_FLUSH));
        // x5 must sit in MEM now: it only advanced on the redirect edge
        seq.push_back(mk(1, 5, 1, 5, 1, 6, 1, 0, 0, 0, E_NONE));
        seq.push_back(mk(0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 11'b0_0_0_0_0_10_10_0_0));
        foreach (seq[i]) begin
            driveStim(seq[i]);
            @(negedge CLK);
            got = obs0; want = expQ.pop_front();
            checks++;
            if (got !== want) begin failures++; $display("[TB] FAIL freeze_redirect[%0d] got=%b want=%b", i, got, want); end
            @(posedge CLK); #1;
        end
        checks++; if (hz0.stall_cnt !== 16'd3) begin failures++; $display("[TB] FAIL freeze_redirect.stall_cnt got=%0d want=3", hz0.stall_cnt); end
        checks++; if (hz0.flush_cnt !== 16'd1) begin failures++; $display("[TB] FAIL freeze_redirect.flush_cnt got=%0d want=1", hz0.flush_cnt); end
    endtask

    task automatic test_reset_mid_freeze();
        stimT        seq[$];
        stimT        s;
        logic [10:0] got, want;
        doReset();
        seq.push_back(mk(1, 1, 1, 2, 1, 5, 1, 0, 0, 0, E_NONE));
        seq.push_back(mk(1, 5, 1, 5, 1, 6, 1, 0, 0, 0, E_NONE));
        seq.push_back(mk(1, 5, 1, 5, 1, 6, 1, 0, 0, 1, 11'b1_1_0_0_1_01_01_0_0));
        s = mk(1, 5, 1, 5, 1, 6, 1, 0, 0, 1, 11'b1_1_0_0_1_01_01_0_0);
        s.rst = 1'b1;
        seq.push_back(s);
        seq.push_back(mk(1, 6, 1, 6, 1, 7, 1, 0, 0, 0, E_NONE));
        seq.push_back(mk(0, 0, 0, 0, 0, 0, 0, 0, 0, 0, E_NONE));
        foreach (seq[i]) begin
            driveStim(seq[i]);
            @(negedge CLK);
            got = obs0; want = expQ.pop_front();
            checks++;
            if (got !== want) begin failures++; $display("[TB] FAIL reset_mid_freeze[%0d] got=%b want=%b", i, got, want); end
            @(posedge CLK); #1;
        end
        checks++; if (hz0.stall_cnt !== 16'd0) begin failures++; $display("[TB] FAIL reset_mid_freeze.stall_cnt got=%0d want=0", hz0.stall_cnt); end
    endtask

    task automatic test_saturation();
        stimT        seq[$];
        logic [10:0] got, want;
        doReset();
        for (int k = 0; k < 5; k++) seq.push_back(mk(0, 0, 0, 0, 0, 0, 0, 0, 1, 0, E_FLUSH));
        for (int k = 0; k < 5; k++) seq.push_back(mk(0, 0, 0, 0, 0, 0, 0, 0, 0, 1, E_FREEZE));
        foreach (seq[i]) begin
            driveStim(seq[i]);
            @(negedge CLK);
            got = obs2; want = expQ.pop_front();
            checks++;
            if (got !== want) begin failures++; $display("[TB] FAIL saturation[%0d] got=%b want=%b", i, got, want); end
            @(posedge CLK); #1;
            if (i == 1) begin
                checks++; if (hz2.flush_cnt !== 2'd2) begin failures++; $display("[TB] FAIL saturation.flush_mid got=%0d want=2", hz2.flush_cnt); end
            end
        end
        checks++; if (hz2.flush_cnt !== 2'd3) begin failures++; $display("[TB] FAIL saturation.flush_cnt got=%0d want=3", hz2.flush_cnt); end
        checks++; if (hz2.stall_cnt !== 2'd3) begin failures++; $display("[TB] FAIL saturation.stall_cnt got=%0d want=3", hz2.stall_cnt); end
    endtask

    initial begin
        #100000;
        $display("[TB] FAIL watchdog expired got=running want=finished");
        $fatal(1, "[TB] watchdog");
    end

    initial begin
        test_reset();
        test_forwarding();
        test_load_use();
        test_raw_nofwd();
        test_redirect_vs_stall();
        test_freeze_redirect();
        test_reset_mid_freeze();
        test_saturation();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
